// File: rtl/ehl_ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the ehl_* bus blocks.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ehl_ahb_pkg;

  // HTRANS transfer types
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  // HRESP codes (2-bit bus field)
  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;

  // HSIZE codes the bridge understands; anything wider is rejected
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Byte-lane strobes for a 32-bit data bus from transfer size and low address bits
  function automatic logic [3:0] ahb_strb(input logic [2:0] hsize, input logic [1:0] addr);
    logic [3:0] strb;
    strb = 4'b0000;
    case (hsize)
      HSIZE_BYTE: strb = 4'b0001 << addr;
      HSIZE_HALF: strb = 4'b0011 << {addr[1], 1'b0};
      HSIZE_WORD: strb = 4'b1111;
      default:    strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ehl_ahb2apb_bridge.sv
// AHB-Lite slave to APB4 master bridge: one APB SETUP/ACCESS per selected AHB transfer.
// Latency: 3 AHB wait states with a zero-wait peripheral, +1 per ACCESS cycle with pready low.
// Backpressure: AHB stalled via hready until the single outstanding APB transfer ends; pslverr/timeout -> 2-cycle ERROR.
// Ports: hclk/hreset (sync, active-high); AHB slave side hsel..hwdata in, hready/hresp/hrdata out;
//        APB master side paddr/psel/penable/pwrite/pprot/pstrb/pwdata out, prdata/pready/pslverr in.
module ehl_ahb2apb_bridge
  import ehl_ahb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          hclk,
  input  logic          hreset,
  input  logic          hsel,
  input  logic          hready_in,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [3:0]    hprot,
  input  logic [31:0]   hwdata,
  output logic          hready,
  output logic [1:0]    hresp,
  output logic [31:0]   hrdata,
  output logic [AW-1:0] paddr,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [2:0]    pprot,
  output logic [3:0]    pstrb,
  output logic [31:0]   pwdata,
  input  logic [31:0]   prdata,
  input  logic          pready,
  input  logic          pslverr
);

  typedef enum logic [2:0] {
    S_IDLE, S_WDAT, S_SETUP, S_ACCESS, S_ERR1, S_ERR2, S_DONE
  } state_e;

  // A disabled timeout still needs a 1-bit counter to keep the logic legal
  localparam int              CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   TMO_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0]   TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e          state_q, state_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic            pwrite_q, pwrite_d;
  logic [2:0]      pprot_q, pprot_d;
  logic [3:0]      pstrb_q, pstrb_d;
  logic [31:0]     pwdata_q, pwdata_d;
  logic [31:0]     hrdata_q, hrdata_d;
  logic            hready_q, hready_d;
  logic [1:0]      hresp_q, hresp_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            xfer_vld;

  logic unused_ok;
  assign unused_ok = &{1'b0, htrans[0], hprot[3:2]};

  assign xfer_vld = hsel & htrans[1] & hready_in & hready_q;

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pprot_d  = pprot_q;
    pstrb_d  = pstrb_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (xfer_vld) begin
          if (hsize > HSIZE_WORD) begin
            // Unsupported width never reaches the APB side
            state_d = S_ERR1;
          end else begin
            state_d  = S_WDAT;
            paddr_d  = haddr;
            pwrite_d = hwrite;
            pprot_d  = {~hprot[0], 1'b1, hprot[1]};
            pstrb_d  = hwrite ? ahb_strb(hsize, haddr[1:0]) : 4'b0000;
          end
        end
      end
      S_WDAT: begin
        // AHB data phase: hwdata is valid now; harmless to capture on reads
        pwdata_d = hwdata;
        state_d  = S_SETUP;
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          if (pslverr) begin
            state_d = S_ERR1;
          end else begin
            state_d = S_DONE;
            if (!pwrite_q) hrdata_d = prdata;
          end
        end else begin
          if (cnt_q != TMO_MAX) cnt_d = cnt_q + 1'b1;
          // This stalled cycle is the TIMEOUT-th one
          if ((TIMEOUT != 0) && (cnt_q == TMO_LAST)) state_d = S_ERR1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = S_IDLE;  // master cancels anything presented here
      default: state_d = S_IDLE;
    endcase

    // Bus-facing controls are registered decodes of the next state
    hready_d  = !(state_d inside {S_WDAT, S_SETUP, S_ACCESS, S_ERR1});
    hresp_d   = (state_d inside {S_ERR1, S_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
    psel_d    = (state_d inside {S_SETUP, S_ACCESS});
    penable_d = (state_d == S_ACCESS);
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= S_IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pprot_q   <= '0;
      pstrb_q   <= '0;
      pwdata_q  <= '0;
      hrdata_q  <= '0;
      hready_q  <= 1'b1;
      hresp_q   <= HRESP_OKAY;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pprot_q   <= pprot_d;
      pstrb_q   <= pstrb_d;
      pwdata_q  <= pwdata_d;
      hrdata_q  <= hrdata_d;
      hready_q  <= hready_d;
      hresp_q   <= hresp_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      cnt_q     <= cnt_d;
    end
  end

  assign hready  = hready_q;
  assign hresp   = hresp_q;
  assign hrdata  = hrdata_q;
  assign paddr   = paddr_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign pprot   = pprot_q;
  assign pstrb   = pstrb_q;
  assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_ehl_ahb2apb_bridge.sv
// Directed self-checking bench for ehl_ahb2apb_bridge (TIMEOUT=4 instance).
// Latency: n/a.
// Backpressure: pready/pslverr driven per scenario.
module tb_ehl_ahb2apb_bridge;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel, hready_in, hwrite;
  logic [31:0] haddr, hwdata, hrdata, paddr, pwdata, prdata;
  logic [1:0]  htrans, hresp;
  logic [2:0]  hsize, pprot;
  logic [3:0]  hprot, pstrb;
  logic        hready, psel, penable, pwrite, pready, pslverr;

  int tests = 0;
  int fails = 0;

  always #5 hclk = ~hclk;

  ehl_ahb2apb_bridge #(.AW(32), .TIMEOUT(4)) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .hready_in(hready_in),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hprot(hprot), .hwdata(hwdata), .hready(hready), .hresp(hresp),
    .hrdata(hrdata), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pprot(pprot), .pstrb(pstrb), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // Advance one cycle; outputs are then sampled 1ns after the edge
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  // Present one address phase now, then idle the bus and run to the first hready=1 cycle.
  task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                          input logic [31:0] wdat, input logic [31:0] rdat, input logic err,
                          output int waits, output logic [3:0] strb, output logic [1:0] resp,
                          output bit saw_psel);
    hsel = 1'b1; htrans = 2'd2; haddr = addr; hwrite = wr; hsize = size; hprot = 4'b0000;
    prdata = rdat; pready = 1'b1; pslverr = err;
    waits = 0; strb = 4'h0; saw_psel = 1'b0;
    step();
    hsel = 1'b0; htrans = 2'd0; hwdata = wdat;
    while (!hready && waits < 64) begin
      waits++;
      if (psel) begin
        saw_psel = 1'b1;
        if (!penable) strb = pstrb;
      end
      step();
    end
    resp = hresp;
    pslverr = 1'b0;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    step(); step();
    tests++; if (hready !== 1'b1) begin fails++; $display("FAIL reset_hready: got %b want 1", hready); end
    tests++; if (hresp !== 2'd0) begin fails++; $display("FAIL reset_hresp: got %0d want 0", hresp); end
    tests++; if ({psel, penable, pwrite} !== 3'b000) begin fails++; $display("FAIL reset_apb_ctl: got %b want 000", {psel, penable, pwrite}); end
    tests++; if ({paddr, pwdata, hrdata} !== 96'd0) begin fails++; $display("FAIL reset_data: got %h/%h/%h want 0", paddr, pwdata, hrdata); end
    tests++; if ({pstrb, pprot} !== 7'd0) begin fails++; $display("FAIL reset_strb_prot: got %b/%b want 0", pstrb, pprot); end
    hreset = 1'b0;
    step();
  endtask

  task automatic test_idle_busy();
    hsel = 1'b1; htrans = 2'd1;  // BUSY
    step();
    tests++; if (hready !== 1'b1 || psel !== 1'b0) begin fails++; $display("FAIL busy_zero_wait: got hready=%b psel=%b want 1/0", hready, psel); end
    htrans = 2'd0;  // IDLE
    step();
    tests++; if (hready !== 1'b1 || hresp !== 2'd0 || psel !== 1'b0) begin fails++; $display("FAIL idle_zero_wait: got hready=%b hresp=%0d psel=%b want 1/0/0", hready, hresp, psel); end
    hsel = 1'b0;
  endtask

  task automatic test_word_write();
    // T0
    hsel = 1'b1; htrans = 2'd2; haddr = 32'h3000_0010; hwrite = 1'b1; hsize = 3'd2; hprot = 4'b0011;
    pready = 1'b1; pslverr = 1'b0;
    step(); // T1 WDAT
    tests++; if (hready !== 1'b0 || psel !== 1'b0) begin fails++; $display("FAIL wr_t1: got hready=%b psel=%b want 0/0", hready, psel); end
    hsel = 1'b0; htrans = 2'd0; hwdata = 32'hA000_00BC;
    step(); // T2 SETUP
    tests++; if (psel !== 1'b1 || penable !== 1'b0) begin fails++; $display("FAIL wr_t2_ctl: got psel=%b penable=%b want 1/0", psel, penable); end
    tests++; if (paddr !== 32'h3000_0010) begin fails++; $display("FAIL wr_paddr: got %h want 30000010", paddr); end
    tests++; if (pwdata !== 32'hA000_00BC) begin fails++; $display("FAIL wr_pwdata: got %h want a00000bc", pwdata); end
    tests++; if (pstrb !== 4'hF || pwrite !== 1'b1) begin fails++; $display("FAIL wr_strb_write: got %h/%b want f/1", pstrb, pwrite); end
    tests++; if (pprot !== 3'b011) begin fails++; $display("FAIL wr_pprot: got %b want 011", pprot); end
    step(); // T3 ACCESS
    tests++; if (psel !== 1'b1 || penable !== 1'b1 || hready !== 1'b0) begin fails++; $display("FAIL wr_t3: got psel=%b penable=%b hready=%b want 1/1/0", psel, penable, hready); end
    tests++; if (paddr !== 32'h3000_0010 || pwdata !== 32'hA000_00BC || pstrb !== 4'hF) begin fails++; $display("FAIL wr_t3_stable: got %h/%h/%h", paddr, pwdata, pstrb); end
    step(); // T4 DONE
    tests++; if (hready !== 1'b1 || hresp !== 2'd0 || psel !== 1'b0) begin fails++; $display("FAIL wr_t4: got hready=%b hresp=%0d psel=%b want 1/0/0", hready, hresp, psel); end
  endtask

  task automatic test_read_wait();
    int waits, acc;
    hsel = 1'b1; htrans = 2'd2; haddr = 32'h3000_0004; hwrite = 1'b0; hsize = 3'd2;
    prdata = 32'h1234_5678; pready = 1'b0;
    waits = 0; acc = 0;
    step();
    hsel = 1'b0; htrans = 2'd0;
    while (!hready && waits < 40) begin
      waits++;
      if (psel && penable) begin
        acc++;
        pready = (acc >= 3);  // low for the first two ACCESS cycles
      end
      step();
    end
    tests++; if (waits !== 5) begin fails++; $display("FAIL rd_waits: got %0d want 5", waits); end
    tests++; if (hrdata !== 32'h1234_5678) begin fails++; $display("FAIL rd_data: got %h want 12345678", hrdata); end
    tests++; if (hresp !== 2'd0) begin fails++; $display("FAIL rd_resp: got %0d want 0", hresp); end
    pready = 1'b1;
  endtask

  task automatic test_strobes();
    int waits; logic [3:0] strb; logic [1:0] resp; bit sp;
    run_xfer(32'h3000_0003, 1'b1, 3'd0, 32'h0000_0000, 32'h0, 1'b0, waits, strb, resp, sp);
    tests++; if (strb !== 4'b1000) begin fails++; $display("FAIL strb_byte3: got %b want 1000", strb); end
    tests++; if (pprot !== 3'b110) begin fails++; $display("FAIL pprot_user_data0: got %b want 110", pprot); end
    run_xfer(32'h3000_0002, 1'b1, 3'd1, 32'h0000_0000, 32'h0, 1'b0, waits, strb, resp, sp);
    tests++; if (strb !== 4'b1100) begin fails++; $display("FAIL strb_half2: got %b want 1100", strb); end
    run_xfer(32'h3000_0001, 1'b1, 3'd0, 32'h0000_0000, 32'h0, 1'b0, waits, strb, resp, sp);
    tests++; if (strb !== 4'b0010 || waits !== 3) begin fails++; $display("FAIL strb_byte1: got %b waits=%0d want 0010/3", strb, waits); end
  endtask

  task automatic test_back_to_back();
    hsel = 1'b1; htrans = 2'd2; haddr = 32'h3000_000C; hwrite = 1'b1; hsize = 3'd2; pready = 1'b1;
    step();
    hsel = 1'b0; htrans = 2'd0; hwdata = 32'h5555_AAAA;
    step(); step(); step(); // T4 DONE
    tests++; if (hready !== 1'b1) begin fails++; $display("FAIL b2b_done1: got hready=%b want 1", hready); end
    hsel = 1'b1; htrans = 2'd2; haddr = 32'h3000_0008; hwrite = 1'b0; prdata = 32'hCAFE_F00D;
    step(); // T5 WDAT
    tests++; if (hready !== 1'b0 || psel !== 1'b0) begin fails++; $display("FAIL b2b_wdat: got hready=%b psel=%b want 0/0", hready, psel); end
    hsel = 1'b0; htrans = 2'd0;
    step(); // T6 SETUP
    tests++; if (psel !== 1'b1 || paddr !== 32'h3000_0008 || pwrite !== 1'b0 || pstrb !== 4'h0) begin fails++; $display("FAIL b2b_setup: got psel=%b paddr=%h pwrite=%b pstrb=%h", psel, paddr, pwrite, pstrb); end
    step(); step(); // T8 DONE
    tests++; if (hready !== 1'b1 || hrdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL b2b_done2: got hready=%b hrdata=%h want 1/cafef00d", hready, hrdata); end
  endtask

  task automatic test_slverr();
    hsel = 1'b1; htrans = 2'd2; haddr = 32'h3000_0014; hwrite = 1'b1; hsize = 3'd2; pready = 1'b1; pslverr = 1'b1;
    step();
    hsel = 1'b0; htrans = 2'd0;
    step(); step(); // T3 ACCESS with pslverr
    tests++; if (penable !== 1'b1) begin fails++; $display("FAIL err_access: got penable=%b want 1", penable); end
    step(); // T4 ERR1
    pslverr = 1'b0;
    tests++; if (hready !== 1'b0 || hresp !== 2'd1 || psel !== 1'b0) begin fails++; $display("FAIL err1: got hready=%b hresp=%0d psel=%b want 0/1/0", hready, hresp, psel); end
    step(); // T5 ERR2
    tests++; if (hready !== 1'b1 || hresp !== 2'd1) begin fails++; $display("FAIL err2: got hready=%b hresp=%0d want 1/1", hready, hresp); end
    step(); // IDLE
    tests++; if (hready !== 1'b1 || hresp !== 2'd0) begin fails++; $display("FAIL err_idle: got hready=%b hresp=%0d want 1/0", hready, hresp); end
  endtask

  task automatic test_timeout();
    int acc, guard;
    hsel = 1'b1; htrans = 2'd2; haddr = 32'h3000_0018; hwrite = 1'b0; hsize = 3'd2; pready = 1'b0;
    acc = 0; guard = 0;
    step();
    hsel = 1'b0; htrans = 2'd0;
    while (hresp !== 2'd1 && guard < 40) begin
      guard++;
      if (psel && penable) acc++;
      step();
    end
    tests++; if (acc !== 4) begin fails++; $display("FAIL tmo_access_cycles: got %0d want 4", acc); end
    tests++; if (psel !== 1'b0 || penable !== 1'b0 || hready !== 1'b0) begin fails++; $display("FAIL tmo_err1: got psel=%b penable=%b hready=%b want 0/0/0", psel, penable, hready); end
    step();
    tests++; if (hready !== 1'b1 || hresp !== 2'd1) begin fails++; $display("FAIL tmo_err2: got hready=%b hresp=%0d want 1/1", hready, hresp); end
    pready = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    int waits; logic [3:0] strb; logic [1:0] resp; bit sp;
    hsel = 1'b1; htrans = 2'd2; haddr = 32'h3000_001C; hwrite = 1'b1; hsize = 3'd2; pready = 1'b0;
    step();
    hsel = 1'b0; htrans = 2'd0; hwdata = 32'h1111_2222;
    step(); step(); // ACCESS
    tests++; if (penable !== 1'b1) begin fails++; $display("FAIL rst_mid_pre: got penable=%b want 1", penable); end
    hreset = 1'b1;
    step();
    tests++; if (psel !== 1'b0 || penable !== 1'b0 || hready !== 1'b1 || hresp !== 2'd0) begin fails++; $display("FAIL rst_mid_ctl: got psel=%b penable=%b hready=%b hresp=%0d", psel, penable, hready, hresp); end
    tests++; if (hrdata !== 32'd0 || paddr !== 32'd0 || pwdata !== 32'd0) begin fails++; $display("FAIL rst_mid_data: got %h/%h/%h want 0", hrdata, paddr, pwdata); end
    hreset = 1'b0; pready = 1'b1;
    run_xfer(32'h3000_0020, 1'b0, 3'd2, 32'h0, 32'h0BAD_BEEF, 1'b0, waits, strb, resp, sp);
    tests++; if (waits !== 3 || resp !== 2'd0 || hrdata !== 32'h0BAD_BEEF) begin fails++; $display("FAIL rst_after_xfer: got waits=%0d resp=%0d hrdata=%h want 3/0/0badbeef", waits, resp, hrdata); end
    run_xfer(32'h3000_0020, 1'b1, 3'd3, 32'h0, 32'h0, 1'b0, waits, strb, resp, sp);
    tests++; if (resp !== 2'd1 || waits !== 1) begin fails++; $display("FAIL hsize3_err: got resp=%0d waits=%0d want 1/1", resp, waits); end
    tests++; if (sp !== 1'b0) begin fails++; $display("FAIL hsize3_no_psel: got psel_seen=%b want 0", sp); end
    step();
    tests++; if (hresp !== 2'd0 || hready !== 1'b1) begin fails++; $display("FAIL hsize3_idle: got hresp=%0d hready=%b want 0/1", hresp, hready); end
  endtask

  initial begin
    hreset = 1'b1; hsel = 1'b0; hready_in = 1'b1; haddr = '0; htrans = 2'd0; hwrite = 1'b0;
    hsize = 3'd2; hprot = 4'b0000; hwdata = '0; prdata = '0; pready = 1'b1; pslverr = 1'b0;
    #1;
    test_reset();
    test_idle_busy();
    test_word_write();
    test_read_wait();
    test_strobes();
    test_back_to_back();
    test_slverr();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
